// File: rtl/cnn_layer_1_pad_loader_if.sv
// Handshake and frame bus between the pixel producer, the pad loader and the layer-1 MAC.
// Widths follow the image geometry; padded sizes are derived and not overridable.
interface cnn_layer_1_pad_loader_if #(
  parameter int IMAGE_WIDTH      = 28,
  parameter int IMAGE_HEIGHT     = 28,
  parameter int PAD              = 1,
  parameter int FEATURE_BITWIDTH = 8
);
  localparam int PADDED_WIDTH  = IMAGE_WIDTH + 2 * PAD;
  localparam int PADDED_HEIGHT = IMAGE_HEIGHT + 2 * PAD;
  localparam int FRAME_BITS    = FEATURE_BITWIDTH * PADDED_WIDTH * PADDED_HEIGHT;

  logic                        in_valid;
  logic                        in_ready;
  logic [FEATURE_BITWIDTH-1:0] in_pixel;
  logic                        in_last;
  logic                        frame_ack;
  logic [FRAME_BITS-1:0]       padded_feature;
  logic                        frame_valid;
  logic                        frame_error;
  logic [7:0]                  frame_count;

  modport master (
    output in_valid, in_pixel, in_last, frame_ack,
    input  in_ready, padded_feature, frame_valid, frame_error, frame_count
  );

  modport slave (
    input  in_valid, in_pixel, in_last, frame_ack,
    output in_ready, padded_feature, frame_valid, frame_error, frame_count
  );
endinterface

// File: rtl/cnn_layer_1_pad_loader.sv
// Raster pixel stream into a zero-bordered frame buffer, presented flat to the layer-1 MAC
// and held until the consumer acknowledges it.
//
// state | meaning
// LOAD  | accepting pixels into the interior
// HOLD  | complete frame presented, waiting for frame_ack
module cnn_layer_1_pad_loader #(
  parameter int IMAGE_WIDTH      = 28,
  parameter int IMAGE_HEIGHT     = 28,
  parameter int PAD              = 1,
  parameter int FEATURE_BITWIDTH = 8
) (
  input logic clk,
  input logic reset,
  cnn_layer_1_pad_loader_if.slave bus
);
  localparam int PADDED_WIDTH  = IMAGE_WIDTH + 2 * PAD;
  localparam int PADDED_HEIGHT = IMAGE_HEIGHT + 2 * PAD;
  localparam int RW = (IMAGE_HEIGHT > 1) ? $clog2(IMAGE_HEIGHT) : 1;
  localparam int CW = (IMAGE_WIDTH > 1) ? $clog2(IMAGE_WIDTH) : 1;

  typedef enum logic {LOAD, HOLD} state_t;

  state_t                      state, state_next;
  logic [RW-1:0]               row;
  logic [CW-1:0]               col;
  logic                        err;
  logic [7:0]                  count;
  logic                        accept;
  logic                        col_end;
  logic                        at_last;
  logic [FEATURE_BITWIDTH-1:0] mem [IMAGE_HEIGHT][IMAGE_WIDTH];

  assign accept  = bus.in_valid && (state == LOAD);
  assign col_end = (col == CW'(IMAGE_WIDTH - 1));
  assign at_last = col_end && (row == RW'(IMAGE_HEIGHT - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= LOAD;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      LOAD:    if (accept && at_last) state_next = HOLD;
      HOLD:    if (bus.frame_ack)     state_next = LOAD;
      default: state_next = LOAD;
    endcase
  end

  // Completion is driven by the pixel count alone; in_last only feeds the sticky error.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      row   <= '0;
      col   <= '0;
      err   <= 1'b0;
      count <= '0;
    end else if (accept) begin
      if (bus.in_last != at_last) err <= 1'b1;
      if (col_end) begin
        col <= '0;
        row <= at_last ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
      if (at_last) count <= count + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)       mem <= '{default: '0};
    else if (accept) mem[row][col] <= bus.in_pixel;
  end

  assign bus.in_ready    = (state == LOAD);
  assign bus.frame_valid = (state == HOLD);
  assign bus.frame_error = err;
  assign bus.frame_count = count;

  // Only the interior has storage; the border is wired to zero.
  for (genvar p = 0; p < PADDED_HEIGHT; p++) begin : g_row
    for (genvar q = 0; q < PADDED_WIDTH; q++) begin : g_col
      if (p >= PAD && p < PAD + IMAGE_HEIGHT && q >= PAD && q < PAD + IMAGE_WIDTH) begin : g_int
        assign bus.padded_feature[FEATURE_BITWIDTH*(p*PADDED_WIDTH+q) +: FEATURE_BITWIDTH] =
          mem[p-PAD][q-PAD];
      end else begin : g_pad
        assign bus.padded_feature[FEATURE_BITWIDTH*(p*PADDED_WIDTH+q) +: FEATURE_BITWIDTH] = '0;
      end
    end
  end
endmodule

// File: tb/tb_cnn_layer_1_pad_loader.sv
// Directed bench for the layer-1 pad loader: reset, full frames, backpressure, gaps,
// in_last errors and mid-frame reset, checked against a reference image array.
module tb_cnn_layer_1_pad_loader;
  localparam int W    = 28;
  localparam int H    = 28;
  localparam int PW   = 30;
  localparam int PH   = 30;
  localparam int NPIX = W * H;
  localparam int TOT  = 8 * PW * PH;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;
  logic [7:0] ref_img [NPIX];

  cnn_layer_1_pad_loader_if bus ();

  cnn_layer_1_pad_loader dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] pix(input int kind, input int idx);
    int v;
    case (kind)
      0:       v = idx;
      1:       v = idx * 3 + 3;
      2:       v = idx * 7 + 1;
      3:       v = (idx * 5 + 11) ^ 32'hA5;
      default: v = idx * 13 + 200;
    endcase
    return v[7:0];
  endfunction

  function automatic logic [TOT-1:0] ref_vec();
    logic [TOT-1:0] v;
    v = '0;
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        v[8*((r+1)*PW+c+1) +: 8] = ref_img[r*W+c];
    return v;
  endfunction

  function automatic logic [7:0] elem(input int p, input int q);
    return bus.padded_feature[8*(p*PW+q) +: 8];
  endfunction

  task automatic do_reset();
    bus.in_valid  = 1'b0;
    bus.in_last   = 1'b0;
    bus.in_pixel  = '0;
    bus.frame_ack = 1'b0;
    reset = 1'b1;
    for (int i = 0; i < NPIX; i++) ref_img[i] = '0;
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic push(input logic [7:0] v, input logic last, input bit gaps);
    int waited;
    if (gaps) begin
      while ($urandom_range(0, 1) == 1) begin
        bus.in_valid = 1'b0;
        bus.in_pixel = 8'($urandom);
        bus.in_last  = 1'($urandom);
        @(posedge clk); #1;
      end
    end
    bus.in_valid = 1'b1;
    bus.in_pixel = v;
    bus.in_last  = last;
    waited = 0;
    while (bus.in_ready !== 1'b1 && waited < 2000) begin
      @(posedge clk); #1;
      waited++;
    end
    vectors++;
    if (bus.in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL push_timeout: in_ready=%b after %0d cycles, required 1", bus.in_ready, waited);
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic stream(input int kind, input int first, input int last_idx,
                        input int early, input bit gaps);
    for (int idx = first; idx <= last_idx; idx++) begin
      ref_img[idx] = pix(kind, idx);
      push(ref_img[idx], (idx == NPIX - 1) || (idx == early), gaps);
    end
  endtask

  task automatic test_reset();
    do_reset();
    vectors++;
    if (bus.in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); end
    vectors++;
    if (bus.frame_valid !== 1'b0) begin miscompares++; $display("FAIL reset_frame_valid: got %b want 0", bus.frame_valid); end
    vectors++;
    if (bus.padded_feature !== '0) begin miscompares++; $display("FAIL reset_padded: nonzero frame after reset"); end
    vectors++;
    if (bus.frame_count !== 8'd0) begin miscompares++; $display("FAIL reset_count: got %0d want 0", bus.frame_count); end
    vectors++;
    if (bus.frame_error !== 1'b0) begin miscompares++; $display("FAIL reset_error: got %b want 0", bus.frame_error); end
  endtask

  task automatic test_stream();
    int nz;
    do_reset();
    stream(0, 0, 1, -1, 0);
    vectors++;
    if (elem(1, 2) !== 8'd1) begin miscompares++; $display("FAIL stream_first_write: elem(1,2)=%h want 01", elem(1, 2)); end
    stream(0, 2, NPIX - 2, -1, 0);
    vectors++;
    if (bus.frame_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL stream_before_last: valid=%b ready=%b want 0 1", bus.frame_valid, bus.in_ready);
    end
    stream(0, NPIX - 1, NPIX - 1, -1, 0);
    vectors++;
    if (bus.frame_valid !== 1'b1 || bus.in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL stream_hold: valid=%b ready=%b want 1 0", bus.frame_valid, bus.in_ready);
    end
    vectors++;
    if (elem(28, 28) !== 8'h0F || elem(1, 1) !== 8'h00 || elem(10, 5) !== 8'h00) begin
      miscompares++;
      $display("FAIL stream_corners: (28,28)=%h (1,1)=%h (10,5)=%h want 0f 00 00", elem(28, 28), elem(1, 1), elem(10, 5));
    end
    vectors++;
    if (bus.padded_feature !== ref_vec()) begin miscompares++; $display("FAIL stream_frame: padded_feature differs from reference"); end
    nz = 0;
    for (int p = 0; p < PH; p++)
      for (int q = 0; q < PW; q++)
        if ((p == 0 || p == PH - 1 || q == 0 || q == PW - 1) && elem(p, q) === 8'h00) nz++;
    vectors++;
    if (nz != 116) begin miscompares++; $display("FAIL stream_border: %0d zero border elements, want 116", nz); end
    vectors++;
    if (bus.frame_count !== 8'd1 || bus.frame_error !== 1'b0) begin
      miscompares++;
      $display("FAIL stream_status: count=%0d err=%b want 1 0", bus.frame_count, bus.frame_error);
    end
  endtask

  task automatic test_backpressure();
    logic [TOT-1:0] saved;
    saved = bus.padded_feature;
    bus.in_valid = 1'b1;
    bus.in_pixel = 8'h7F;
    bus.in_last  = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      vectors++;
      if (bus.in_ready !== 1'b0) begin miscompares++; $display("FAIL bp_ready: cycle %0d in_ready=%b want 0", i, bus.in_ready); end
    end
    bus.in_valid = 1'b0;
    vectors++;
    if (bus.padded_feature !== saved || bus.frame_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL bp_frozen: frame changed or valid=%b want 1", bus.frame_valid);
    end
    bus.frame_ack = 1'b1;
    @(posedge clk); #1;
    bus.frame_ack = 1'b0;
    vectors++;
    if (bus.in_ready !== 1'b1 || bus.frame_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL bp_release: ready=%b valid=%b want 1 0", bus.in_ready, bus.frame_valid);
    end
    stream(1, 0, 0, -1, 0);
    vectors++;
    if (elem(1, 1) !== 8'h03 || elem(1, 2) !== 8'h01) begin
      miscompares++;
      $display("FAIL bp_next_pixel: (1,1)=%h (1,2)=%h want 03 01", elem(1, 1), elem(1, 2));
    end
    stream(1, 1, NPIX - 1, -1, 0);
    vectors++;
    if (bus.padded_feature !== ref_vec() || bus.frame_count !== 8'd2) begin
      miscompares++;
      $display("FAIL bp_second_frame: count=%0d want 2 or frame differs", bus.frame_count);
    end
  endtask

  task automatic test_gaps();
    do_reset();
    bus.frame_ack = 1'b1;
    stream(2, 0, NPIX - 1, -1, 1);
    vectors++;
    if (bus.frame_valid !== 1'b1 || bus.padded_feature !== ref_vec() || bus.frame_count !== 8'd1) begin
      miscompares++;
      $display("FAIL gaps_frame1: valid=%b count=%0d want 1 1 or frame differs", bus.frame_valid, bus.frame_count);
    end
    stream(3, 0, NPIX - 1, -1, 1);
    vectors++;
    if (bus.frame_valid !== 1'b1 || bus.padded_feature !== ref_vec() || bus.frame_count !== 8'd2) begin
      miscompares++;
      $display("FAIL gaps_frame2: valid=%b count=%0d want 1 2 or frame differs", bus.frame_valid, bus.frame_count);
    end
    @(posedge clk); #1;
    bus.frame_ack = 1'b0;
    vectors++;
    if (bus.frame_valid !== 1'b0 || bus.frame_error !== 1'b0) begin
      miscompares++;
      $display("FAIL gaps_ack: valid=%b err=%b want 0 0", bus.frame_valid, bus.frame_error);
    end
  endtask

  task automatic test_early_last();
    do_reset();
    stream(4, 0, 100, 100, 0);
    vectors++;
    if (bus.frame_error !== 1'b1 || bus.frame_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL early_last: err=%b valid=%b want 1 0", bus.frame_error, bus.frame_valid);
    end
    stream(4, 101, NPIX - 1, 100, 0);
    vectors++;
    if (bus.frame_valid !== 1'b1 || bus.frame_count !== 8'd1 || bus.frame_error !== 1'b1) begin
      miscompares++;
      $display("FAIL early_complete: valid=%b count=%0d err=%b want 1 1 1", bus.frame_valid, bus.frame_count, bus.frame_error);
    end
    bus.frame_ack = 1'b1;
    @(posedge clk); #1;
    bus.frame_ack = 1'b0;
    stream(0, 0, NPIX - 1, -1, 0);
    vectors++;
    if (bus.frame_error !== 1'b1 || bus.frame_count !== 8'd2 || bus.padded_feature !== ref_vec()) begin
      miscompares++;
      $display("FAIL early_sticky: err=%b count=%0d want 1 2 or frame differs", bus.frame_error, bus.frame_count);
    end
  endtask

  task automatic test_mid_reset();
    do_reset();
    stream(1, 0, 399, -1, 0);
    #2 reset = 1'b1;
    #1;
    for (int i = 0; i < NPIX; i++) ref_img[i] = '0;
    vectors++;
    if (bus.in_ready !== 1'b1 || bus.frame_valid !== 1'b0 || bus.padded_feature !== '0 || bus.frame_count !== 8'd0) begin
      miscompares++;
      $display("FAIL mid_reset: ready=%b valid=%b count=%0d want 1 0 0, buffer cleared", bus.in_ready, bus.frame_valid, bus.frame_count);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    stream(3, 0, NPIX - 2, -1, 0);
    vectors++;
    if (bus.frame_valid !== 1'b0) begin miscompares++; $display("FAIL mid_reset_early_valid: valid=%b want 0", bus.frame_valid); end
    stream(3, NPIX - 1, NPIX - 1, -1, 0);
    vectors++;
    if (bus.frame_valid !== 1'b1 || bus.padded_feature !== ref_vec() || bus.frame_count !== 8'd1) begin
      miscompares++;
      $display("FAIL mid_reset_frame: valid=%b count=%0d want 1 1 or frame differs", bus.frame_valid, bus.frame_count);
    end
    #2 reset = 1'b1;
    #1;
    vectors++;
    if (bus.frame_valid !== 1'b0 || bus.frame_count !== 8'd0) begin
      miscompares++;
      $display("FAIL hold_reset: valid=%b count=%0d want 0 0", bus.frame_valid, bus.frame_count);
    end
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_gaps();
    test_early_last();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/cnn_layer_1_pad_loader.md
# cnn_layer_1_pad_loader

Stream-to-frame loader upstream of the layer-1 convolution MAC. Accepts a raster-order pixel stream over a valid/ready handshake, writes each pixel into a zero-bordered frame buffer, and presents the complete padded frame as one flat vector in the layout the MAC consumes. Holds the frame stable until the consumer acknowledges it, then reopens for the next frame.

## Interface
- IMAGE_WIDTH, 28, unpadded image columns
- IMAGE_HEIGHT, 28, unpadded image rows
- PAD, 1, zero-border width on every side ("same" padding for a 3x3 kernel)
- FEATURE_BITWIDTH, 8, signed pixel width
- Derived, not overridable: PADDED_WIDTH = IMAGE_WIDTH+2*PAD, PADDED_HEIGHT = IMAGE_HEIGHT+2*PAD, NPIX = IMAGE_WIDTH*IMAGE_HEIGHT

- clk  in  1  single clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- in_valid  in  1  in_pixel carries a pixel
- in_ready  out  1  loader accepts a pixel this cycle
- in_pixel  in  FEATURE_BITWIDTH  pixel value, raster order (row 0 col 0 first)
- in_last  in  1  producer marks final pixel of a frame; checked only
- frame_ack  in  1  consumer has captured the frame; release buffer
- padded_feature  out  FEATURE_BITWIDTH*PADDED_WIDTH*PADDED_HEIGHT  padded frame; element at padded (row p, col q) is bits [FEATURE_BITWIDTH*(p*PADDED_WIDTH+q) +: FEATURE_BITWIDTH]
- frame_valid  out  1  padded_feature holds a complete, stable frame
- frame_error  out  1  sticky: in_last mismatch seen
- frame_count  out  8  completed frames, wraps 255->0

## Operation
- States: LOAD (filling), HOLD (frame presented). Reset state LOAD.
- in_ready = (state==LOAD); frame_valid = (state==HOLD). Both are registered-state decodes, with no combinational path from inputs.
- Accept = in_valid && in_ready. On accept, pixel at stream index (r,c) is written to padded position (r+PAD, c+PAD); col counter c increments, wraps at IMAGE_WIDTH-1 to 0 and increments r.
- Border elements (p<PAD, p>=PAD+IMAGE_HEIGHT, q<PAD, q>=PAD+IMAGE_WIDTH) are constant zero and never written; they need no storage.
- Interior is not cleared between frames; every interior element is overwritten each frame.
- Accept of pixel NPIX-1 (r=IMAGE_HEIGHT-1, c=IMAGE_WIDTH-1): write it, reset r,c to 0, go to HOLD, frame_count+1.
- in_last check on each accept: in_last=1 at index != NPIX-1, or in_last=0 at index NPIX-1, sets frame_error. Frame completion is driven by the count only, never by in_last. frame_error clears only on reset.
- HOLD: padded_feature frozen; in_valid ignored (in_ready=0). frame_ack=1 moves to LOAD next edge.
- frame_ack in LOAD: ignored.

## Timing
- Reset values: in_ready=1, frame_valid=0, frame_error=0, frame_count=0, padded_feature all zero, r=c=0.
- A pixel accepted at edge N is visible on padded_feature after edge N.
- Last pixel accepted at edge N: after edge N, frame_valid=1, in_ready=0, and padded_feature contains the full frame in the same cycle frame_valid rises.
- The MAC registers its result one edge after its input. The consumer asserts frame_ack no earlier than the cycle after frame_valid rises. The loader does not enforce this.
- frame_ack sampled high at edge M in HOLD: after edge M, frame_valid=0, in_ready=1. The earliest next accept is at edge M+1. Minimum frame period is NPIX+1 cycles with continuous in_valid and frame_ack held high.
- in_valid gaps are allowed anywhere; counters advance only on accept.
- Reset mid-frame: partial frame discarded, state LOAD, counters 0, buffer zeroed.
- Reset in HOLD: frame_valid drops asynchronously with reset; frame not counted again.

## Test plan
- Reset then idle: after reset deassert, in_ready=1, frame_valid=0, padded_feature==0, frame_count=0, frame_error=0.
- Stream 784 pixels, value = (idx mod 256) as signed 8-bit, in_valid held high, in_last on idx 783 -> frame_valid rises the cycle after accept 783; element (r+1,c+1) = idx value; all 116 border elements = 0; frame_count=1; frame_error=0.
- Backpressure: in HOLD, drive in_valid=1 with value 0x7F for 10 cycles -> no accepts, padded_feature unchanged; then frame_ack one cycle -> in_ready=1 on the next cycle, and the next accepted pixel lands at (1,1).
- Random in_valid gaps (~50% duty) over two frames with distinct data -> second frame fully overwrites the first; frame_count=2; output matches the reference image model bit-exactly.
- in_last asserted early at idx 100 -> frame_error=1 and stays 1; frame still completes at idx 783; frame_error remains 1 after the next good frame.
- Reset asserted at idx 400, then a full new frame -> frame_valid only after 784 new accepts; interior = new data; frame_count=1.
